// File: rtl/ysyx_25040111_xbar_arb_pkg.sv
// Shared definitions for the N-master request/response arbiter:
// FSM encodings, arbitration-mode constants and an index-width helper.
package ysyx_25040111_xbar_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam int RR_FIXED = 0;
    localparam int RR_ROUND = 1;
    localparam int BEAT_W   = 8;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_25040111_xbar_arb_rrpick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping.
// Tying ptr to zero gives plain lowest-index fixed priority.
module ysyx_25040111_rrpick
    import ysyx_25040111_xbar_arb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path leaves a value held (no latch).
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ysyx_25040111_xbar_arb.sv
// N-master to 1-slave arbiter: grant held for the whole transaction,
// fixed or round-robin selection, burst length checked against the response.
module ysyx_25040111_xbar_arb
    import ysyx_25040111_xbar_arb_pkg::*;
#(
    parameter  int N_MST   = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int RR_MODE = 1,
    localparam int IDX_W   = idx_width(N_MST),
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_MST-1:0]          m_req_valid,
    output logic [N_MST-1:0]          m_req_ready,
    input  logic [N_MST-1:0]          m_req_write,
    input  logic [N_MST*ADDR_W-1:0]   m_req_addr,
    input  logic [N_MST*DATA_W-1:0]   m_req_wdata,
    input  logic [N_MST*STRB_W-1:0]   m_req_wstrb,
    input  logic [N_MST*BEAT_W-1:0]   m_req_len,
    output logic [N_MST-1:0]          m_resp_valid,
    output logic [DATA_W-1:0]         m_resp_data,
    output logic                      m_resp_last,
    output logic                      m_resp_err,
    output logic                      s_req_valid,
    input  logic                      s_req_ready,
    output logic                      s_req_write,
    output logic [ADDR_W-1:0]         s_req_addr,
    output logic [DATA_W-1:0]         s_req_wdata,
    output logic [STRB_W-1:0]         s_req_wstrb,
    output logic [BEAT_W-1:0]         s_req_len,
    input  logic                      s_resp_valid,
    input  logic [DATA_W-1:0]         s_resp_data,
    input  logic                      s_resp_last,
    input  logic                      s_resp_err,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      len_err
);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, pick_ptr, pick_idx;
    logic [N_MST-1:0]   pick_gnt;
    logic               pick_any;
    logic [BEAT_W-1:0]  beat_cnt, len_q;
    logic               accept, resp_fire, resp_end;

    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [STRB_W-1:0]  sel_wstrb;
    logic [BEAT_W-1:0]  sel_len;

    assign pick_ptr = (RR_MODE == RR_ROUND) ? rr_ptr : '0;

    ysyx_25040111_rrpick #(.N(N_MST), .IDX_W(IDX_W)) u_pick (
        .req (m_req_valid),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        sel_len   = '0;
        for (int i = 0; i < N_MST; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_write = m_req_write[i];
                sel_addr  = m_req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = m_req_wstrb[i*STRB_W +: STRB_W];
                sel_len   = m_req_len[i*BEAT_W +: BEAT_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign resp_end = s_resp_last || (beat_cnt == len_q);

    // While reset is held every handshake output is forced low, which also
    // suppresses the beat that arrives in the abort cycle.
    always_comb begin
        state_nxt    = state;
        m_req_ready  = '0;
        m_resp_valid = '0;
        m_resp_last  = 1'b0;
        s_req_valid  = 1'b0;
        accept       = 1'b0;
        resp_fire    = 1'b0;
        if (reset) begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        accept      = 1'b1;
                        m_req_ready = pick_gnt;
                        state_nxt   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    s_req_valid = 1'b1;
                    if (s_req_ready) state_nxt = ST_RESP;
                end
                ST_RESP: begin
                    if (s_resp_valid) begin
                        resp_fire              = 1'b1;
                        m_resp_valid[grant_id] = 1'b1;
                        m_resp_last            = resp_end;
                        if (resp_end) state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign m_resp_data = resp_fire ? s_resp_data : '0;
    assign m_resp_err  = resp_fire && s_resp_err;
    assign busy        = (state != ST_IDLE);

    // NOTE: the latched request fields drive outputs directly, so they are
    // reset like control state rather than left uninitialised.
    always_ff @(posedge clock) begin
        if (!reset) begin
            grant_id    <= '0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            len_err     <= 1'b0;
            len_q       <= '0;
            s_req_write <= 1'b0;
            s_req_addr  <= '0;
            s_req_wdata <= '0;
            s_req_wstrb <= '0;
        end else begin
            if (accept) begin
                grant_id    <= pick_idx;
                s_req_write <= sel_write;
                s_req_addr  <= sel_addr;
                s_req_wdata <= sel_wdata;
                s_req_wstrb <= sel_wstrb;
                // Writes always complete on one beat whatever len says.
                len_q       <= sel_write ? '0 : sel_len;
            end
            if (state == ST_ISSUE && s_req_ready) beat_cnt <= '0;
            if (resp_fire) begin
                if (beat_cnt != {BEAT_W{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
                if ((s_resp_last && beat_cnt < len_q) ||
                    (!s_resp_last && beat_cnt == len_q))
                    len_err <= 1'b1;
                if (resp_end && RR_MODE == RR_ROUND)
                    rr_ptr <= (grant_id == IDX_W'(N_MST - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    assign s_req_len = len_q;

endmodule

// File: tb/tb_ysyx_25040111_xbar_arb.sv
// Directed bench: a round-robin and a fixed-priority instance share all
// inputs and are checked cycle by cycle against hand-computed values.
module tb_ysyx_25040111_xbar_arb;

    logic        clock, reset;
    logic [1:0]  m_req_valid, m_req_write;
    logic [63:0] m_req_addr, m_req_wdata;
    logic [7:0]  m_req_wstrb;
    logic [15:0] m_req_len;
    logic        s_req_ready, s_resp_valid, s_resp_last, s_resp_err;
    logic [31:0] s_resp_data;

    logic [1:0]  rr_ready, rr_respv, fp_ready, fp_respv;
    logic [31:0] rr_rdata, fp_rdata, rr_addr, fp_addr, rr_wdata, fp_wdata;
    logic        rr_rlast, fp_rlast, rr_rerr, fp_rerr, rr_sreqv, fp_sreqv;
    logic        rr_write, fp_write, rr_gid, fp_gid, rr_busy, fp_busy;
    logic        rr_lerr, fp_lerr;
    logic [3:0]  rr_wstrb, fp_wstrb;
    logic [7:0]  rr_len, fp_len;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_25040111_xbar_arb #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(1)) dut_rr (
        .clock(clock), .reset(reset),
        .m_req_valid(m_req_valid), .m_req_ready(rr_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_req_len(m_req_len), .m_resp_valid(rr_respv), .m_resp_data(rr_rdata),
        .m_resp_last(rr_rlast), .m_resp_err(rr_rerr), .s_req_valid(rr_sreqv),
        .s_req_ready(s_req_ready), .s_req_write(rr_write), .s_req_addr(rr_addr),
        .s_req_wdata(rr_wdata), .s_req_wstrb(rr_wstrb), .s_req_len(rr_len),
        .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data), .s_resp_last(s_resp_last),
        .s_resp_err(s_resp_err), .grant_id(rr_gid), .busy(rr_busy), .len_err(rr_lerr)
    );

    ysyx_25040111_xbar_arb #(.N_MST(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0)) dut_fp (
        .clock(clock), .reset(reset),
        .m_req_valid(m_req_valid), .m_req_ready(fp_ready), .m_req_write(m_req_write),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_req_len(m_req_len), .m_resp_valid(fp_respv), .m_resp_data(fp_rdata),
        .m_resp_last(fp_rlast), .m_resp_err(fp_rerr), .s_req_valid(fp_sreqv),
        .s_req_ready(s_req_ready), .s_req_write(fp_write), .s_req_addr(fp_addr),
        .s_req_wdata(fp_wdata), .s_req_wstrb(fp_wstrb), .s_req_len(fp_len),
        .s_resp_valid(s_resp_valid), .s_resp_data(s_resp_data), .s_resp_last(s_resp_last),
        .s_resp_err(s_resp_err), .grant_id(fp_gid), .busy(fp_busy), .len_err(fp_lerr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_req(input int m, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [7:0] len);
        m_req_write[m]        = wr;
        m_req_addr[m*32 +: 32] = addr;
        m_req_wdata[m*32 +: 32] = wdata;
        m_req_wstrb[m*4 +: 4]  = wstrb;
        m_req_len[m*8 +: 8]    = len;
    endtask

    task automatic beat(input logic v, input logic [31:0] d, input logic l, input logic e);
        s_resp_valid = v;
        s_resp_data  = d;
        s_resp_last  = l;
        s_resp_err   = e;
    endtask

    initial begin
        reset = 1'b0;
        m_req_valid = 2'b11; m_req_write = '0; m_req_addr = '0;
        m_req_wdata = '0; m_req_wstrb = '0; m_req_len = '0;
        s_req_ready = 1'b0;
        beat(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state, with requests present to show ready stays low.
        step(); step(); #1;
        check("rst_ready", rr_ready, 2'b00);
        check("rst_ready_fp", fp_ready, 2'b00);
        check("rst_busy", rr_busy, 1'b0);
        check("rst_grant", rr_gid, 1'b0);
        check("rst_sreqv", rr_sreqv, 1'b0);
        check("rst_respv", rr_respv, 2'b00);
        check("rst_lenerr", rr_lerr, 1'b0);
        check("rst_addr", rr_addr, 32'h0);
        step(); reset = 1'b1; m_req_valid = 2'b00;

        // Single read by master 1.
        step(); set_req(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 8'd0); m_req_valid = 2'b10; #1;
        check("sr_ready", rr_ready, 2'b10);
        check("sr_sreqv_early", rr_sreqv, 1'b0);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1; #1;
        check("sr_sreqv", rr_sreqv, 1'b1);
        check("sr_addr", rr_addr, 32'h8000_0010);
        check("sr_write", rr_write, 1'b0);
        check("sr_len", rr_len, 8'd0);
        check("sr_grant", rr_gid, 1'b1);
        step(); s_req_ready = 1'b0; beat(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0); #1;
        check("sr_respv", rr_respv, 2'b10);
        check("sr_data", rr_rdata, 32'hDEAD_BEEF);
        check("sr_last", rr_rlast, 1'b1);
        check("sr_sreqv_off", rr_sreqv, 1'b0);
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("sr_busy_drop", rr_busy, 1'b0);

        // Fairness: both masters request continuously.
        set_req(0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 8'd0);
        set_req(1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 8'd0);
        s_req_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            logic [1:0] exp_oh;
            exp_oh = (t % 2 == 1) ? 2'b10 : 2'b01;
            step(); m_req_valid = 2'b11; beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
            check($sformatf("rr_ready_%0d", t), rr_ready, exp_oh);
            check($sformatf("fp_ready_%0d", t), fp_ready, 2'b01);
            step(); #1;
            check($sformatf("rr_grant_%0d", t), rr_gid, exp_oh[1]);
            check($sformatf("fp_grant_%0d", t), fp_gid, 1'b0);
            step(); beat(1'b1, 32'(t), 1'b1, 1'b0); #1;
            check($sformatf("rr_respv_%0d", t), rr_respv, exp_oh);
            check($sformatf("fp_respv_%0d", t), fp_respv, 2'b01);
        end
        step(); m_req_valid = 2'b00; s_req_ready = 1'b0; beat(1'b0, 32'h0, 1'b0, 1'b0);

        // Four-beat burst by master 0; error flag passes through on beat 3.
        step(); set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 8'd3); m_req_valid = 2'b01; #1;
        check("bu_ready", rr_ready, 2'b01);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1; #1;
        check("bu_len", rr_len, 8'd3);
        for (int i = 0; i < 4; i++) begin
            step(); s_req_ready = 1'b0; beat(1'b1, 32'(i + 1), i == 3, i == 2); #1;
            check($sformatf("bu_respv_%0d", i), rr_respv, 2'b01);
            check($sformatf("bu_data_%0d", i), rr_rdata, 32'(i + 1));
            check($sformatf("bu_last_%0d", i), rr_rlast, i == 3);
            check($sformatf("bu_err_%0d", i), rr_rerr, i == 2);
        end
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("bu_busy", rr_busy, 1'b0);
        check("bu_lenerr", rr_lerr, 1'b0);

        // Early last: len 3 but slave ends on beat 2.
        step(); set_req(0, 1'b0, 32'h0000_0140, 32'h0, 4'h0, 8'd3); m_req_valid = 2'b01; #1;
        check("el_ready", rr_ready, 2'b01);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1;
        step(); s_req_ready = 1'b0; beat(1'b1, 32'h11, 1'b0, 1'b0); #1;
        check("el_last_b1", rr_rlast, 1'b0);
        step(); beat(1'b1, 32'h22, 1'b1, 1'b0); #1;
        check("el_respv_b2", rr_respv, 2'b01);
        check("el_last_b2", rr_rlast, 1'b1);
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("el_busy", rr_busy, 1'b0);
        check("el_lenerr", rr_lerr, 1'b1);
        check("el_lenerr_fp", fp_lerr, 1'b1);
        // A clean single-beat read does not clear the sticky flag.
        step(); set_req(1, 1'b0, 32'h0000_0180, 32'h0, 4'h0, 8'd0); m_req_valid = 2'b10; #1;
        check("cl_ready", rr_ready, 2'b10);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1;
        step(); s_req_ready = 1'b0; beat(1'b1, 32'h33, 1'b1, 1'b0); #1;
        check("cl_respv", rr_respv, 2'b10);
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("cl_lenerr", rr_lerr, 1'b1);

        // Write by master 0 with 5 cycles of downstream backpressure.
        step(); set_req(0, 1'b1, 32'h0000_1000, 32'hA5A5_0000, 4'b1100, 8'd0); m_req_valid = 2'b01; #1;
        check("wr_ready", rr_ready, 2'b01);
        for (int c = 0; c < 5; c++) begin
            step(); m_req_valid = 2'b00; s_req_ready = 1'b0; #1;
            check($sformatf("wr_sreqv_%0d", c), rr_sreqv, 1'b1);
            check($sformatf("wr_addr_%0d", c), rr_addr, 32'h0000_1000);
            check($sformatf("wr_wdata_%0d", c), rr_wdata, 32'hA5A5_0000);
            check($sformatf("wr_wstrb_%0d", c), rr_wstrb, 4'b1100);
            check($sformatf("wr_write_%0d", c), rr_write, 1'b1);
        end
        step(); s_req_ready = 1'b1; #1;
        check("wr_sreqv_hs", rr_sreqv, 1'b1);
        step(); s_req_ready = 1'b0; beat(1'b1, 32'h0, 1'b1, 1'b0); #1;
        check("wr_respv", rr_respv, 2'b01);
        check("wr_last", rr_rlast, 1'b1);
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("wr_busy", rr_busy, 1'b0);

        // Reset at beat 2 of an 8-beat read by master 1 (RR pointer is 1 here).
        step(); set_req(1, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 8'd7); m_req_valid = 2'b10; #1;
        check("rm_ready", rr_ready, 2'b10);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1;
        step(); s_req_ready = 1'b0; beat(1'b1, 32'h1, 1'b0, 1'b0); #1;
        check("rm_respv_b0", rr_respv, 2'b10);
        step(); beat(1'b1, 32'h2, 1'b0, 1'b0);
        step(); reset = 1'b0; beat(1'b1, 32'h3, 1'b0, 1'b0); #1;
        check("rm_respv_abort", rr_respv, 2'b00);
        step(); reset = 1'b1; beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("rm_busy", rr_busy, 1'b0);
        check("rm_respv", rr_respv, 2'b00);
        check("rm_sreqv", rr_sreqv, 1'b0);
        check("rm_grant", rr_gid, 1'b0);
        check("rm_lenerr", rr_lerr, 1'b0);

        // Fresh request from both: pointer back at 0, so master 0 wins.
        // len 1 with no slave last exercises the overrun path.
        step(); set_req(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 8'd1);
        set_req(1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 8'd0); m_req_valid = 2'b11; #1;
        check("fr_ready", rr_ready, 2'b01);
        step(); m_req_valid = 2'b00; s_req_ready = 1'b1; #1;
        check("fr_sreqv", rr_sreqv, 1'b1);
        check("fr_addr", rr_addr, 32'h0000_3000);
        step(); s_req_ready = 1'b0; beat(1'b1, 32'hA, 1'b0, 1'b0); #1;
        check("ov_last_b0", rr_rlast, 1'b0);
        step(); beat(1'b1, 32'hB, 1'b0, 1'b0); #1;
        check("ov_respv_b1", rr_respv, 2'b01);
        check("ov_last_b1", rr_rlast, 1'b1);
        step(); beat(1'b1, 32'hC, 1'b0, 1'b0); #1;
        check("ov_extra_drop", rr_respv, 2'b00);
        check("ov_busy", rr_busy, 1'b0);
        check("ov_lenerr", rr_lerr, 1'b1);
        step(); beat(1'b0, 32'h0, 1'b0, 1'b0); #1;
        check("ov_idle", rr_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
